// File: rtl/wb_stack.sv
// wb_stack: write-back stage data/return stack register file.
// Data stack (T/N views) and return stack (R view), committed from the
// EX/WB pointer and write inputs, with sticky overflow/underflow flags and
// high-water marks.
// Optional feature macro: WB_BYPASS_EN -- forwards the not-yet-committed
// pointers and write data to the outputs in the same cycle.
module wb_stack #(
    parameter int DSK_DEPTH = 32,
    parameter int RSK_DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  dsp_n_i,
    input  logic [7:0]  rsp_n_i,
    input  logic        dsk_wen_i,
    input  logic        rsk_wen_i,
    input  logic [15:0] dsk_data_i,
    input  logic [15:0] rsk_data_i,
    input  logic        hold_flag_i,
    input  logic        err_clr_i,
    output logic [7:0]  dsp_o,
    output logic [7:0]  rsp_o,
    output logic [15:0] dsk_top_o,
    output logic [15:0] dsk_next_o,
    output logic [15:0] rsk_top_o,
    output logic        dsk_ovf_o,
    output logic        dsk_unf_o,
    output logic        rsk_ovf_o,
    output logic        rsk_unf_o,
    output logic [7:0]  dsk_hwm_o,
    output logic [7:0]  rsk_hwm_o
);

    localparam int DAW = $clog2(DSK_DEPTH);
    localparam int RAW = $clog2(RSK_DEPTH);
    localparam logic [8:0] DSK_LIM = 9'(DSK_DEPTH);
    localparam logic [8:0] RSK_LIM = 9'(RSK_DEPTH);

    logic [15:0] dsk_mem_q [DSK_DEPTH];
    logic [15:0] dsk_mem_d [DSK_DEPTH];
    logic [15:0] rsk_mem_q [RSK_DEPTH];
    logic [15:0] rsk_mem_d [RSK_DEPTH];

    logic [7:0] dsp_q, dsp_d, rsp_q, rsp_d;
    logic [7:0] dsk_hwm_q, dsk_hwm_d, rsk_hwm_q, rsk_hwm_d;
    logic       dsk_ovf_q, dsk_ovf_d, dsk_unf_q, dsk_unf_d;
    logic       rsk_ovf_q, rsk_ovf_d, rsk_unf_q, rsk_unf_d;

    logic           commit;
    logic [DAW-1:0] dsk_widx;
    logic [RAW-1:0] rsk_widx;
    logic           dsk_ovf_evt, dsk_unf_evt, rsk_ovf_evt, rsk_unf_evt;
    logic           dsk_in_range, rsk_in_range;

    assign commit   = ~hold_flag_i;
    assign dsk_widx = dsp_n_i[DAW-1:0];
    assign rsk_widx = rsp_n_i[RAW-1:0];

    // Error events: underflow is the 0 -> 8'hFF pop; any other out-of-range
    // pointer counts as overflow, so a single pop below zero is not also
    // reported as an overflow.
    always_comb begin
        dsk_in_range = ({1'b0, dsp_n_i} < DSK_LIM);
        rsk_in_range = ({1'b0, rsp_n_i} < RSK_LIM);
        dsk_unf_evt  = commit && (dsp_q == 8'h00) && (dsp_n_i == 8'hFF);
        rsk_unf_evt  = commit && (rsp_q == 8'h00) && (rsp_n_i == 8'hFF);
        dsk_ovf_evt  = commit && !dsk_in_range && !dsk_unf_evt;
        rsk_ovf_evt  = commit && !rsk_in_range && !rsk_unf_evt;
    end

    // Next-state for pointers, arrays, sticky flags and high-water marks.
    always_comb begin
        dsp_d     = dsp_q;
        rsp_d     = rsp_q;
        dsk_mem_d = dsk_mem_q;
        rsk_mem_d = rsk_mem_q;
        dsk_ovf_d = dsk_ovf_q;
        dsk_unf_d = dsk_unf_q;
        rsk_ovf_d = rsk_ovf_q;
        rsk_unf_d = rsk_unf_q;
        dsk_hwm_d = dsk_hwm_q;
        rsk_hwm_d = rsk_hwm_q;
        if (commit) begin
            dsp_d = dsp_n_i;
            rsp_d = rsp_n_i;
            if (dsk_wen_i) dsk_mem_d[dsk_widx] = dsk_data_i;
            if (rsk_wen_i) rsk_mem_d[rsk_widx] = rsk_data_i;
            // A set event in the same cycle wins over the clear.
            if (err_clr_i) begin
                dsk_ovf_d = 1'b0;
                dsk_unf_d = 1'b0;
                rsk_ovf_d = 1'b0;
                rsk_unf_d = 1'b0;
                dsk_hwm_d = 8'h00;
                rsk_hwm_d = 8'h00;
            end
            if (dsk_ovf_evt) dsk_ovf_d = 1'b1;
            if (dsk_unf_evt) dsk_unf_d = 1'b1;
            if (rsk_ovf_evt) rsk_ovf_d = 1'b1;
            if (rsk_unf_evt) rsk_unf_d = 1'b1;
            // Compare against the registered mark so a clear does not make a
            // small pointer look like a new maximum in the same cycle.
            if (dsk_in_range && (dsp_n_i > dsk_hwm_q)) dsk_hwm_d = dsp_n_i;
            if (rsk_in_range && (rsp_n_i > rsk_hwm_q)) rsk_hwm_d = rsp_n_i;
        end
    end

    // State registers; reset also clears both arrays and drops any pending write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dsp_q     <= 8'h00;
            rsp_q     <= 8'h00;
            dsk_hwm_q <= 8'h00;
            rsk_hwm_q <= 8'h00;
            dsk_ovf_q <= 1'b0;
            dsk_unf_q <= 1'b0;
            rsk_ovf_q <= 1'b0;
            rsk_unf_q <= 1'b0;
            for (int i = 0; i < DSK_DEPTH; i++) dsk_mem_q[i] <= 16'h0000;
            for (int i = 0; i < RSK_DEPTH; i++) rsk_mem_q[i] <= 16'h0000;
        end else begin
            dsp_q     <= dsp_d;
            rsp_q     <= rsp_d;
            dsk_hwm_q <= dsk_hwm_d;
            rsk_hwm_q <= rsk_hwm_d;
            dsk_ovf_q <= dsk_ovf_d;
            dsk_unf_q <= dsk_unf_d;
            rsk_ovf_q <= rsk_ovf_d;
            rsk_unf_q <= rsk_unf_d;
            dsk_mem_q <= dsk_mem_d;
            rsk_mem_q <= rsk_mem_d;
        end
    end

    assign dsk_ovf_o = dsk_ovf_q;
    assign dsk_unf_o = dsk_unf_q;
    assign rsk_ovf_o = rsk_ovf_q;
    assign rsk_unf_o = rsk_unf_q;
    assign dsk_hwm_o = dsk_hwm_q;
    assign rsk_hwm_o = rsk_hwm_q;

`ifdef WB_BYPASS_EN
    logic           byp;
    logic [DAW-1:0] t_idx, n_idx;
    logic [RAW-1:0] r_idx;

    // Stack views show post-commit contents; bypass is off during reset and hold.
    always_comb begin
        byp        = !rst && commit;
        dsp_o      = byp ? dsp_n_i : dsp_q;
        rsp_o      = byp ? rsp_n_i : rsp_q;
        t_idx      = dsp_o[DAW-1:0];
        n_idx      = t_idx - DAW'(1);
        r_idx      = rsp_o[RAW-1:0];
        dsk_top_o  = dsk_mem_q[t_idx];
        dsk_next_o = dsk_mem_q[n_idx];
        rsk_top_o  = rsk_mem_q[r_idx];
        if (byp && dsk_wen_i && (dsk_widx == t_idx)) dsk_top_o  = dsk_data_i;
        if (byp && dsk_wen_i && (dsk_widx == n_idx)) dsk_next_o = dsk_data_i;
        if (byp && rsk_wen_i && (rsk_widx == r_idx)) rsk_top_o  = rsk_data_i;
    end
`else
    logic [DAW-1:0] t_idx, n_idx;
    logic [RAW-1:0] r_idx;

    // Registered views only: outputs depend on committed state, never on inputs.
    always_comb begin
        dsp_o      = dsp_q;
        rsp_o      = rsp_q;
        t_idx      = dsp_q[DAW-1:0];
        n_idx      = t_idx - DAW'(1);
        r_idx      = rsp_q[RAW-1:0];
        dsk_top_o  = dsk_mem_q[t_idx];
        dsk_next_o = dsk_mem_q[n_idx];
        rsk_top_o  = rsk_mem_q[r_idx];
    end
`endif

endmodule

// File: tb/tb_wb_stack.sv
// Directed self-checking bench for wb_stack (depth 32 on both stacks).
module tb_wb_stack;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  dsp_n_i, rsp_n_i;
    logic        dsk_wen_i, rsk_wen_i;
    logic [15:0] dsk_data_i, rsk_data_i;
    logic        hold_flag_i, err_clr_i;
    logic [7:0]  dsp_o, rsp_o;
    logic [15:0] dsk_top_o, dsk_next_o, rsk_top_o;
    logic        dsk_ovf_o, dsk_unf_o, rsk_ovf_o, rsk_unf_o;
    logic [7:0]  dsk_hwm_o, rsk_hwm_o;

    int checks   = 0;
    int failures = 0;

    wb_stack #(.DSK_DEPTH(32), .RSK_DEPTH(32)) dut (
        .clk(clk), .rst(rst),
        .dsp_n_i(dsp_n_i), .rsp_n_i(rsp_n_i),
        .dsk_wen_i(dsk_wen_i), .rsk_wen_i(rsk_wen_i),
        .dsk_data_i(dsk_data_i), .rsk_data_i(rsk_data_i),
        .hold_flag_i(hold_flag_i), .err_clr_i(err_clr_i),
        .dsp_o(dsp_o), .rsp_o(rsp_o),
        .dsk_top_o(dsk_top_o), .dsk_next_o(dsk_next_o), .rsk_top_o(rsk_top_o),
        .dsk_ovf_o(dsk_ovf_o), .dsk_unf_o(dsk_unf_o),
        .rsk_ovf_o(rsk_ovf_o), .rsk_unf_o(rsk_unf_o),
        .dsk_hwm_o(dsk_hwm_o), .rsk_hwm_o(rsk_hwm_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one commit cycle, then park in hold so the outputs show committed state.
    task automatic step(input logic [7:0] dn, input logic dw, input logic [15:0] dd,
                        input logic [7:0] rn, input logic rw, input logic [15:0] rd,
                        input logic clr);
        dsp_n_i = dn; dsk_wen_i = dw; dsk_data_i = dd;
        rsp_n_i = rn; rsk_wen_i = rw; rsk_data_i = rd;
        err_clr_i = clr; hold_flag_i = 1'b0;
        @(posedge clk);
        #1;
        hold_flag_i = 1'b1; dsk_wen_i = 1'b0; rsk_wen_i = 1'b0; err_clr_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; hold_flag_i = 1'b1; err_clr_i = 1'b0;
        dsp_n_i = 8'h00; rsp_n_i = 8'h00; dsk_wen_i = 1'b0; rsk_wen_i = 1'b0;
        dsk_data_i = 16'h0; rsk_data_i = 16'h0;
        #12;
        chk("rst_dsp", 16'(dsp_o), 16'h0);
        chk("rst_T", dsk_top_o, 16'h0);
        chk("rst_N", dsk_next_o, 16'h0);
        chk("rst_R", rsk_top_o, 16'h0);
        chk("rst_flags", 16'({dsk_ovf_o, dsk_unf_o, rsk_ovf_o, rsk_unf_o}), 16'h0);
        chk("rst_hwm", {dsk_hwm_o, rsk_hwm_o}, 16'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // First push
        step(8'd1, 1'b1, 16'hA5A5, 8'd0, 1'b0, 16'h0, 1'b0);
        chk("push1_dsp", 16'(dsp_o), 16'd1);
        chk("push1_T", dsk_top_o, 16'hA5A5);
        chk("push1_N", dsk_next_o, 16'h0);
        chk("push1_hwm", 16'(dsk_hwm_o), 16'd1);

        // Two pushes, pop, then re-read retained entry
        step(8'd1, 1'b1, 16'h1111, 8'd0, 1'b0, 16'h0, 1'b0);
        chk("p11_T", dsk_top_o, 16'h1111);
        step(8'd2, 1'b1, 16'h2222, 8'd0, 1'b0, 16'h0, 1'b0);
        chk("p22_T", dsk_top_o, 16'h2222);
        chk("p22_N", dsk_next_o, 16'h1111);
        chk("p22_hwm", 16'(dsk_hwm_o), 16'd2);
        step(8'd1, 1'b0, 16'h0, 8'd0, 1'b0, 16'h0, 1'b0);
        chk("pop_T", dsk_top_o, 16'h1111);
        chk("pop_N", dsk_next_o, 16'h0);
        step(8'd2, 1'b0, 16'h0, 8'd0, 1'b0, 16'h0, 1'b0);
        chk("ret2_T", dsk_top_o, 16'h2222);

        // Hold with write and clear pending: nothing changes
        dsp_n_i = 8'd5; dsk_wen_i = 1'b1; dsk_data_i = 16'h5555; err_clr_i = 1'b1;
        hold_flag_i = 1'b1;
        @(posedge clk); #1;
        chk("hold_dsp", 16'(dsp_o), 16'd2);
        chk("hold_T", dsk_top_o, 16'h2222);
        chk("hold_hwm", 16'(dsk_hwm_o), 16'd2);
        step(8'd5, 1'b0, 16'h0, 8'd0, 1'b0, 16'h0, 1'b0);
        chk("hold_mem5", dsk_top_o, 16'h0);
        chk("rel_dsp", 16'(dsp_o), 16'd5);
        step(8'd5, 1'b1, 16'h5555, 8'd0, 1'b0, 16'h0, 1'b0);
        chk("rel_T", dsk_top_o, 16'h5555);
        chk("rel_hwm", 16'(dsk_hwm_o), 16'd5);

        // Underflow then overflow on the data stack
        step(8'd0, 1'b0, 16'h0, 8'd0, 1'b0, 16'h0, 1'b0);
        chk("z_N_wrap", dsk_next_o, 16'h0);
        step(8'hFF, 1'b0, 16'h0, 8'd0, 1'b0, 16'h0, 1'b0);
        chk("unf_flag", 16'(dsk_unf_o), 16'h1);
        chk("unf_dsp", 16'(dsp_o), 16'h00FF);
        chk("unf_hwm", 16'(dsk_hwm_o), 16'd5);
        step(8'd32, 1'b1, 16'h7777, 8'd0, 1'b0, 16'h0, 1'b0);
        chk("ovf_flag", 16'(dsk_ovf_o), 16'h1);
        chk("ovf_T_idx0", dsk_top_o, 16'h7777);
        chk("ovf_hwm", 16'(dsk_hwm_o), 16'd5);
        step(8'd1, 1'b0, 16'h0, 8'd0, 1'b0, 16'h0, 1'b0);
        chk("ovf_N_idx0", dsk_next_o, 16'h7777);
        chk("unf_sticky", 16'(dsk_unf_o), 16'h1);

        // Return stack overflow and underflow
        step(8'd1, 1'b0, 16'h0, 8'd40, 1'b0, 16'h0, 1'b0);
        chk("rovf_flag", 16'(rsk_ovf_o), 16'h1);
        step(8'd1, 1'b0, 16'h0, 8'd0, 1'b0, 16'h0, 1'b0);
        step(8'd1, 1'b0, 16'h0, 8'hFF, 1'b0, 16'h0, 1'b0);
        chk("runf_flag", 16'(rsk_unf_o), 16'h1);

        // Clear flags and marks
        step(8'd1, 1'b0, 16'h0, 8'd0, 1'b0, 16'h0, 1'b1);
        chk("clr_flags", 16'({dsk_ovf_o, dsk_unf_o, rsk_ovf_o, rsk_unf_o}), 16'h0);
        chk("clr_hwm", {dsk_hwm_o, rsk_hwm_o}, 16'h0);
        // Set beats clear in the same cycle
        step(8'd40, 1'b0, 16'h0, 8'd0, 1'b0, 16'h0, 1'b1);
        chk("set_prio", 16'(dsk_ovf_o), 16'h1);

        // Return push, then reset in mid-cycle
        step(8'd1, 1'b0, 16'h0, 8'd3, 1'b1, 16'h0ABC, 1'b0);
        chk("rpush_R", rsk_top_o, 16'h0ABC);
        chk("rpush_hwm", 16'(rsk_hwm_o), 16'd3);
        rsp_n_i = 8'd3; rsk_wen_i = 1'b1; rsk_data_i = 16'h1234; hold_flag_i = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("mrst_R", rsk_top_o, 16'h0);
        chk("mrst_rsp", 16'(rsp_o), 16'h0);
        chk("mrst_dsp", 16'(dsp_o), 16'h0);
        @(posedge clk); #1;
        rst = 1'b0; hold_flag_i = 1'b1; rsk_wen_i = 1'b0;
        step(8'd0, 1'b0, 16'h0, 8'd3, 1'b0, 16'h0, 1'b0);
        chk("post_rst_rsp", 16'(rsp_o), 16'd3);
        chk("post_rst_R3", rsk_top_o, 16'h0);
        chk("post_rst_ovf", 16'(dsk_ovf_o), 16'h0);

`ifdef WB_BYPASS_EN
        dsp_n_i = 8'd4; dsk_wen_i = 1'b1; dsk_data_i = 16'hBEEF; hold_flag_i = 1'b0;
        #1;
        chk("byp_dsp", 16'(dsp_o), 16'd4);
        chk("byp_T", dsk_top_o, 16'hBEEF);
        @(posedge clk); #1;
        hold_flag_i = 1'b1; dsk_wen_i = 1'b0;
        chk("byp_commit_T", dsk_top_o, 16'hBEEF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
